timer_bank: RTL and testbench

- Parametrised successor to the team's single free-running counter.
- Provides CHANNELS independent up-counters sharing one programmable prescaler.
- Each channel has its own period, enable, one-shot/periodic mode and restart, and emits a one-cycle terminal pulse on wrap.
- Sits beside clock-divider and PWM logic; its pulses drive periodic events (blink, sampling strobes, timeouts).

---
 rtl/timer_bank_if.sv | 25 ++
 rtl/timer_bank.sv | 88 ++++++++
 tb/tb_timer_bank.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/timer_bank_if.sv
// Control/status bundle for timer_bank: per-channel configuration in, counts and events out.
interface timer_bank_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int PWIDTH   = 8
);
    logic [PWIDTH-1:0]         prescale;
    logic [CHANNELS-1:0]       en;
    logic [CHANNELS-1:0]       oneshot;
    logic [CHANNELS-1:0]       restart;
    logic [CHANNELS*WIDTH-1:0] top;
    logic [CHANNELS*WIDTH-1:0] cnt;
    logic [CHANNELS-1:0]       i;
    logic [CHANNELS-1:0]       done;

    modport master (
        output prescale, en, oneshot, restart, top,
        input  cnt, i, done
    );

    modport slave (
        input  prescale, en, oneshot, restart, top,
        output cnt, i, done
    );
endinterface

// File: rtl/timer_bank.sv
// Bank of independent up-counters driven by one shared prescaler tick; each channel
// wraps at top-1, pulses i on wrap, and can stop itself after one period.
module timer_bank #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int PWIDTH   = 8
) (
    input  logic          clk,
    input  logic          rst,
    timer_bank_if.slave   bus
);
    logic [PWIDTH-1:0] pcnt_reg;
    logic [PWIDTH-1:0] pcnt_next;
    logic              tick;

    // >= rather than == so that lowering prescale never forces a full 2^PWIDTH run-on.
    assign tick = (pcnt_reg >= bus.prescale);

    always_comb begin
        pcnt_next = pcnt_reg + PWIDTH'(1);
        if (tick) begin
            pcnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_reg <= '0;
        end else begin
            pcnt_reg <= pcnt_next;
        end
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [WIDTH-1:0] top_k;
            logic [WIDTH-1:0] term;
            logic [WIDTH-1:0] cnt_reg;
            logic [WIDTH-1:0] cnt_next;
            logic             i_reg;
            logic             i_next;
            logic             done_reg;
            logic             done_next;

            assign top_k = bus.top[gi*WIDTH +: WIDTH];
            // top=0 wraps to all-ones here, giving a full 2^WIDTH period.
            assign term  = top_k - WIDTH'(1);

            always_comb begin
                cnt_next  = cnt_reg;
                i_next    = 1'b0;
                done_next = done_reg;
                if (bus.restart[gi]) begin
                    cnt_next  = '0;
                    done_next = 1'b0;
                end else if (done_reg) begin
                    cnt_next = cnt_reg;
                end else if (bus.en[gi] && tick) begin
                    if (cnt_reg >= term) begin
                        cnt_next = '0;
                        i_next   = 1'b1;
                        if (bus.oneshot[gi]) begin
                            done_next = 1'b1;
                        end
                    end else begin
                        cnt_next = cnt_reg + WIDTH'(1);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg  <= '0;
                    i_reg    <= 1'b0;
                    done_reg <= 1'b0;
                end else begin
                    cnt_reg  <= cnt_next;
                    i_reg    <= i_next;
                    done_reg <= done_next;
                end
            end

            assign bus.cnt[gi*WIDTH +: WIDTH] = cnt_reg;
            assign bus.i[gi]                  = i_reg;
            assign bus.done[gi]               = done_reg;
        end
    endgenerate
endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: stimulus queues per-cycle expectations, a monitor
// process checks them one clock later against the DUT outputs.
module tb_timer_bank;
    localparam int W = 8;
    localparam int C = 4;
    localparam int P = 8;

    logic clk;
    logic rst;

    timer_bank_if #(.WIDTH(W), .CHANNELS(C), .PWIDTH(P)) bus ();

    timer_bank #(.WIDTH(W), .CHANNELS(C), .PWIDTH(P)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          ch;
        logic [W-1:0] cnt;
        logic        iv;
        logic        dv;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic push_exp(input int ch, input int c, input bit iv, input bit dv, input string tag);
        exp_t e;
        e.due = cyc + 1;
        e.ch  = ch;
        e.cnt = W'(c);
        e.iv  = iv;
        e.dv  = dv;
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_top(input int ch, input int v);
        bus.top[ch*W +: W] = W'(v);
    endtask

    task automatic clear_inputs();
        bus.prescale = '0;
        bus.en       = '0;
        bus.oneshot  = '0;
        bus.restart  = '0;
        bus.top      = '0;
    endtask

    // Reset is applied with whatever inputs the previous test left running.
    task automatic do_reset();
        rst = 1'b1;
        for (int ch = 0; ch < C; ch++) push_exp(ch, 0, 1'b0, 1'b0, "reset");
        step();
        rst = 1'b0;
        clear_inputs();
    endtask

    // Monitor: compares every expectation that falls due on this clock.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (q.size() > 0 && q[0].due <= cyc) begin
                exp_t e;
                e = q.pop_front();
                checks++;
                if (e.due != cyc) begin
                    errors++;
                    $display("FAIL %s ch%0d: checked at cycle %0d, required cycle %0d", e.tag, e.ch, cyc, e.due);
                end else if (bus.cnt[e.ch*W +: W] !== e.cnt || bus.i[e.ch] !== e.iv || bus.done[e.ch] !== e.dv) begin
                    errors++;
                    $display("FAIL %s ch%0d cyc %0d: got cnt=%0d i=%b done=%b, required cnt=%0d i=%b done=%b",
                             e.tag, e.ch, cyc, bus.cnt[e.ch*W +: W], bus.i[e.ch], bus.done[e.ch], e.cnt, e.iv, e.dv);
                end else begin
                    $display("ok   %s ch%0d cyc %0d cnt=%0d i=%b done=%b", e.tag, e.ch, cyc, e.cnt, e.iv, e.dv);
                end
            end
        end
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached with %0d expectations pending, required 0", q.size());
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int eff;
        bit iv;
        rst = 1'b1;
        clear_inputs();
        bus.en = '1;
        set_top(0, 4);
        step();

        // Reset overrides enabled channels; then basic periodic, top=4.
        do_reset();
        bus.en[0] = 1'b1;
        set_top(0, 4);
        for (int k = 1; k <= 12; k++) begin
            push_exp(0, k % 4, (k % 4) == 0, 1'b0, "periodic");
            if (k == 1) push_exp(1, 0, 1'b0, 1'b0, "idle_ch1");
            step();
        end

        // top=1: pulse on every tick (prescale=1), cnt held at 0. Left with pcnt=1.
        do_reset();
        bus.prescale = P'(1);
        bus.en[0]    = 1'b1;
        set_top(0, 1);
        for (int k = 1; k <= 7; k++) begin
            push_exp(0, 0, (k % 2) == 0, 1'b0, "top1");
            step();
        end

        // Prescale=2, top=3, with a disabled window; relies on pcnt having been reset.
        do_reset();
        bus.prescale = P'(2);
        set_top(0, 3);
        for (int k = 1; k <= 36; k++) begin
            bus.en[0] = !(k >= 23 && k <= 28);
            if (k <= 22)      eff = k / 3;
            else if (k <= 28) eff = 7;
            else              eff = k / 3 - 2;
            iv = bus.en[0] && (k % 3 == 0) && (eff % 3 == 0);
            push_exp(0, eff % 3, iv, 1'b0, "prescale");
            step();
        end

        // One-shot on ch1, oneshot cleared while stopped, then restart re-arms.
        do_reset();
        set_top(1, 5);
        bus.oneshot[1] = 1'b1;
        bus.en[1]      = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            if (k == 7) bus.oneshot[1] = 1'b0;
            if (k == 11) begin
                bus.restart[1] = 1'b1;
                bus.oneshot[1] = 1'b1;
            end else begin
                bus.restart[1] = 1'b0;
            end
            if (k <= 4)       push_exp(1, k, 1'b0, 1'b0, "oneshot");
            else if (k == 5)  push_exp(1, 0, 1'b1, 1'b1, "oneshot");
            else if (k <= 10) push_exp(1, 0, 1'b0, 1'b1, "oneshot");
            else if (k == 11) push_exp(1, 0, 1'b0, 1'b0, "oneshot");
            else if (k <= 15) push_exp(1, k - 11, 1'b0, 1'b0, "oneshot");
            else if (k == 16) push_exp(1, 0, 1'b1, 1'b1, "oneshot");
            else              push_exp(1, 0, 1'b0, 1'b1, "oneshot");
            step();
        end

        // top lowered 10 -> 3 while cnt=7 on ch3.
        do_reset();
        bus.en[3] = 1'b1;
        set_top(3, 10);
        for (int k = 1; k <= 11; k++) begin
            if (k >= 8) set_top(3, 3);
            if (k <= 7)       push_exp(3, k, 1'b0, 1'b0, "top_drop");
            else if (k == 8)  push_exp(3, 0, 1'b1, 1'b0, "top_drop");
            else if (k <= 10) push_exp(3, k - 8, 1'b0, 1'b0, "top_drop");
            else              push_exp(3, 0, 1'b1, 1'b0, "top_drop");
            step();
        end

        // Restart coinciding with the terminal count beats the pulse and done.
        do_reset();
        bus.en[0]      = 1'b1;
        bus.oneshot[0] = 1'b1;
        set_top(0, 4);
        for (int k = 1; k <= 9; k++) begin
            bus.restart[0] = (k == 4);
            if (k <= 3)      push_exp(0, k, 1'b0, 1'b0, "collide");
            else if (k == 4) push_exp(0, 0, 1'b0, 1'b0, "collide");
            else if (k <= 7) push_exp(0, k - 4, 1'b0, 1'b0, "collide");
            else if (k == 8) push_exp(0, 0, 1'b1, 1'b1, "collide");
            else             push_exp(0, 0, 1'b0, 1'b1, "collide");
            step();
        end

        // top=0 gives a full 256-tick period.
        do_reset();
        bus.en[2] = 1'b1;
        set_top(2, 0);
        for (int k = 1; k <= 258; k++) begin
            push_exp(2, k % 256, k == 256, 1'b0, "top0");
            step();
        end

        // Four channels with coprime periods; all pulse together at clk 210.
        do_reset();
        bus.en = '1;
        set_top(0, 2);
        set_top(1, 3);
        set_top(2, 5);
        set_top(3, 7);
        for (int k = 1; k <= 210; k++) begin
            push_exp(0, k % 2, (k % 2) == 0, 1'b0, "indep");
            push_exp(1, k % 3, (k % 3) == 0, 1'b0, "indep");
            push_exp(2, k % 5, (k % 5) == 0, 1'b0, "indep");
            push_exp(3, k % 7, (k % 7) == 0, 1'b0, "indep");
            step();
        end

        @(posedge clk);
        #2;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
